// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// scoreboard slot layout, FSM states and the per-operand forwarding rule.
package pipeline_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } hz_state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } sb_slot_t;

  // Loads cannot forward from MEM (data not back yet) but can from WB.
  function automatic fwd_sel_t fwd_pick(logic [4:0] rs, sb_slot_t mem, sb_slot_t wb);
    if (mem.valid && mem.reg_write && !mem.mem_read && mem.rd != 5'd0 && mem.rd == rs)
      return FWD_MEM;
    if (wb.valid && wb.reg_write && wb.rd != 5'd0 && wb.rd == rs)
      return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipeline_fwd_unit.sv
// Operand forwarding selects for the EX-stage ALU muxes, derived from the
// EX source registers against the MEM and WB scoreboard slots.
module pipeline_fwd_unit
  import pipeline_pkg::*;
(
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  sb_slot_t   mem,
  input  sb_slot_t   wb,
  output fwd_sel_t   fwd_a,
  output fwd_sel_t   fwd_b
);

  assign fwd_a = fwd_pick(ex_rs1, mem, wb);
  assign fwd_b = fwd_pick(ex_rs2, mem, wb);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: EX/MEM/WB scoreboard,
// forwarding, load-use stall and post-redirect flush. Optional perf counters
// are enabled with the HAZARD_PERF_EN macro.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int XLEN         = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            id_valid_i,
  input  logic [4:0]      id_rs1_i,
  input  logic [4:0]      id_rs2_i,
  input  logic            id_uses_rs1_i,
  input  logic            id_uses_rs2_i,
  input  logic [4:0]      id_rd_i,
  input  logic            id_reg_write_i,
  input  logic            id_mem_read_i,
  input  logic            ex_pc_select_i,
  input  logic            mem_stall_i,
  output logic            stall_if_o,
  output logic            stall_id_o,
  output logic            bubble_ex_o,
  output logic            freeze_o,
  output logic            flush_o,
  output logic [1:0]      fwd_a_o,
  output logic [1:0]      fwd_b_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [XLEN-1:0] lu_stall_cnt_o,
  output logic [XLEN-1:0] flush_cnt_o
`endif
);

  localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

  sb_slot_t  ex, mem, wb, id_slot;
  hz_state_t state;
  logic [2:0] cnt;
  logic      lu, redirect, flush_act, lu_take;
  fwd_sel_t  fwd_a, fwd_b;

  always_comb begin
    id_slot = '{valid: 1'b1, rd: id_rd_i, reg_write: id_reg_write_i,
                mem_read: id_mem_read_i, rs1: id_rs1_i, rs2: id_rs2_i};
    lu = ex.valid & ex.mem_read & (ex.rd != 5'd0) & id_valid_i &
         ((id_uses_rs1_i & (id_rs1_i == ex.rd)) | (id_uses_rs2_i & (id_rs2_i == ex.rd)));
    redirect  = ex_pc_select_i & ~mem_stall_i;
    flush_act = ~mem_stall_i & (ex_pc_select_i | (state == ST_FLUSH));
    // A flush kills the consumer anyway, so load-use is dropped under it.
    lu_take   = lu & ~mem_stall_i & ~flush_act;
  end

  assign flush_o     = flush_act;
  assign bubble_ex_o = lu_take;
  assign stall_if_o  = mem_stall_i | lu_take;
  assign stall_id_o  = mem_stall_i | lu_take;
  assign freeze_o    = mem_stall_i;
  assign fwd_a_o     = fwd_a;
  assign fwd_b_o     = fwd_b;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ex  <= '0;
      mem <= '0;
      wb  <= '0;
    end else if (!mem_stall_i) begin
      wb  <= mem;
      mem <= ex;
      // Empty slots carry rs=x0 so they can never request a forward.
      ex  <= (id_valid_i && !flush_act && !lu_take) ? id_slot : '0;
    end
  end

  // The redirect cycle itself is the first flush cycle, so cnt counts the rest.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else if (!mem_stall_i) begin
      if (redirect) begin
        cnt   <= CNT_LOAD;
        state <= (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
      end else if (state == ST_FLUSH) begin
        if (cnt <= 3'd1) begin
          cnt   <= '0;
          state <= ST_RUN;
        end else begin
          cnt <= cnt - 3'd1;
        end
      end
    end
  end

  pipeline_fwd_unit u_fwd (
    .ex_rs1 (ex.rs1),
    .ex_rs2 (ex.rs2),
    .mem    (mem),
    .wb     (wb),
    .fwd_a  (fwd_a),
    .fwd_b  (fwd_b)
  );

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lu_stall_cnt_o <= '0;
      flush_cnt_o    <= '0;
    end else begin
      if (lu_take && lu_stall_cnt_o != '1)
        lu_stall_cnt_o <= lu_stall_cnt_o + 1'b1;
      if (redirect && state == ST_RUN && flush_cnt_o != '1)
        flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end
`else
  // Perf counters not built.
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed hazard scenarios plus random traffic,
// all checked every cycle against an instruction-level pipeline model.
module tb_pipeline_hazard_ctrl;

  localparam int FC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, id_valid, u1, u2, rw, mr, pc_sel, mstall;
  logic [4:0] rs1, rs2, rd;
  logic       stall_if, stall_id, bubble, freeze, flush;
  logic [1:0] fwd_a, fwd_b;

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(FC), .XLEN(32)) dut (
    .clk_i(clk), .reset_i(reset), .id_valid_i(id_valid),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_uses_rs1_i(u1), .id_uses_rs2_i(u2),
    .id_rd_i(rd), .id_reg_write_i(rw), .id_mem_read_i(mr),
    .ex_pc_select_i(pc_sel), .mem_stall_i(mstall),
    .stall_if_o(stall_if), .stall_id_o(stall_id), .bubble_ex_o(bubble),
    .freeze_o(freeze), .flush_o(flush), .fwd_a_o(fwd_a), .fwd_b_o(fwd_b)
  );

  int nchk = 0, nfail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: instructions in flight (0=EX,1=MEM,2=WB) and flush cycles still owed.
  typedef struct { bit v; int rd; bit rw; bit mr; int rs1; int rs2; } ins_t;
  ins_t pipe[3];
  int   flush_left;
  bit   e_fl, e_bub;

  function automatic bit hit(ins_t s, int rs);
    return s.v && s.rw && s.rd != 0 && s.rd == rs;
  endfunction

  function automatic int fsel(int rs);
    if (hit(pipe[1], rs) && !pipe[1].mr) return 1;
    if (hit(pipe[2], rs)) return 2;
    return 0;
  endfunction

  task automatic settle_chk();
    bit lu;
    #1;
    lu = pipe[0].v && pipe[0].mr && pipe[0].rd != 0 && id_valid &&
         ((u1 && int'(rs1) == pipe[0].rd) || (u2 && int'(rs2) == pipe[0].rd));
    e_fl  = !mstall && (flush_left > 0 || pc_sel);
    e_bub = !mstall && lu && !e_fl;
    chk("flush", flush, e_fl);
    chk("bubble", bubble, e_bub);
    chk("stall_if", stall_if, mstall || e_bub);
    chk("stall_id", stall_id, mstall || e_bub);
    chk("freeze", freeze, mstall);
    chk("fwd_a", fwd_a, fsel(pipe[0].rs1));
    chk("fwd_b", fwd_b, fsel(pipe[0].rs2));
  endtask

  task automatic model_clear();
    ins_t z = '{default: 0};
    for (int i = 0; i < 3; i++) pipe[i] = z;
    flush_left = 0;
  endtask

  task automatic adv();
    ins_t z = '{default: 0};
    if (reset) model_clear();
    else if (!mstall) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (id_valid && !e_fl && !e_bub) ?
                '{v: 1, rd: rd, rw: rw, mr: mr, rs1: rs1, rs2: rs2} : z;
      if (pc_sel) flush_left = FC - 1;
      else if (flush_left > 0) flush_left--;
    end
    @(negedge clk);
  endtask

  task automatic step(); settle_chk(); adv(); endtask

  task automatic idle();
    id_valid = 0; rs1 = 0; rs2 = 0; u1 = 0; u2 = 0; rd = 0; rw = 0; mr = 0;
  endtask

  task automatic ins(input int d, input int s1, input int s2, input bit w, input bit l);
    id_valid = 1; rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2);
    u1 = 1; u2 = 1; rw = w; mr = l;
  endtask

  initial begin
    idle(); pc_sel = 0; mstall = 0; reset = 1;
    @(negedge clk); @(negedge clk);
    model_clear();
    reset = 0;

    // Idle after reset: everything low.
    for (int i = 0; i < 3; i++) begin
      settle_chk(); chk("rst_flush", flush, 0); chk("rst_fwd_a", fwd_a, 0); adv();
    end

    // ADD x5 -> SUB x5 back-to-back, then with a gap.
    ins(5, 1, 2, 1, 0); step();
    ins(6, 5, 3, 1, 0); step();
    idle(); settle_chk(); chk("fwd_mem", fwd_a, 2'b01); adv();
    ins(5, 1, 2, 1, 0); step();
    ins(8, 1, 1, 1, 0); step();
    ins(6, 5, 3, 1, 0); step();
    idle(); settle_chk(); chk("fwd_wb", fwd_a, 2'b10); adv();

    // LW x7 -> ADD using x7 as rs2.
    ins(7, 1, 0, 1, 1); step();
    ins(9, 2, 7, 1, 0); u1 = 0;
    settle_chk(); chk("lu_stall", stall_if, 1); chk("lu_bub", bubble, 1); adv();
    settle_chk(); chk("lu_once", bubble, 0); adv();
    idle(); settle_chk(); chk("lu_fwd_b", fwd_b, 2'b10); adv();

    // Redirect coinciding with load-use: flush only.
    ins(7, 1, 0, 1, 1); step();
    ins(9, 7, 0, 1, 0); pc_sel = 1;
    settle_chk(); chk("rd_flush", flush, 1); chk("rd_nostall", stall_if, 0); adv();
    pc_sel = 0; settle_chk(); chk("fl_2nd", flush, 1); adv();
    idle(); settle_chk(); chk("fl_done", flush, 0); adv();

    // Memory stall over a pending redirect and forward.
    ins(5, 1, 2, 1, 0); step();
    ins(6, 5, 3, 1, 0); step();
    idle(); pc_sel = 1; mstall = 1;
    for (int i = 0; i < 3; i++) begin
      settle_chk(); chk("ms_freeze", freeze, 1); chk("ms_fwd", fwd_a, 2'b01); adv();
    end
    mstall = 0;
    settle_chk(); chk("ms_flush", flush, 1); chk("ms_fwd_after", fwd_a, 2'b01); adv();
    pc_sel = 0; step(); step();

    // x0 never forwards, never stalls.
    ins(0, 1, 2, 1, 0); step();
    ins(4, 0, 0, 1, 0); step();
    idle(); settle_chk(); chk("x0_fwd", fwd_a, 0); adv();
    ins(0, 1, 2, 1, 1); step();
    ins(4, 0, 0, 1, 0); settle_chk(); chk("x0_nolu", stall_if, 0); adv();

    // Reset mid-flush.
    idle(); pc_sel = 1; step();
    pc_sel = 0; reset = 1; step();
    reset = 0; settle_chk(); chk("rst_midflush", flush, 0); adv();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      id_valid = ($urandom_range(0, 9) < 8);
      rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
      rd  = 5'($urandom_range(0, 3));
      u1 = 1'($urandom); u2 = 1'($urandom); rw = 1'($urandom);
      mr = rw && ($urandom_range(0, 9) < 4);
      pc_sel = ($urandom_range(0, 19) == 0);
      mstall = ($urandom_range(0, 9) == 0);
      reset  = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
